// File: rtl/scalar_point_mult_if.sv
// Request/result bundle of the scalar point multiplier: operands, start strobe, result and status.
interface scalar_point_mult_if #(
    parameter int N   = 3,
    parameter int K_W = 4
);
    logic           start;
    logic [K_W-1:0] k;
    logic [N-1:0]   X0;
    logic [N-1:0]   Y0;
    logic [N-1:0]   Z0;
    logic [N-1:0]   X1;
    logic [N-1:0]   Y1;
    logic [N-1:0]   Z1;
    logic           busy;
    logic           done;

    modport master (
        output start, k, X0, Y0, Z0,
        input  X1, Y1, Z1, busy, done
    );

    modport slave (
        input  start, k, X0, Y0, Z0,
        output X1, Y1, Z1, busy, done
    );
endinterface

// File: rtl/scalar_point_mult.sv
// Double-and-add scalar multiplier Q = k*P on y^2 = x^3 + 1 over GF(7), MSB first.
// Latency: done pulses in the cycle after edge 2*K_W counted from the accepting edge.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
module scalar_point_mult #(
    parameter int N   = 3,
    parameter int K_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    scalar_point_mult_if.slave bus
);
    localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [N-1:0] MODP = N'(7);

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] z;
    } point_t;

    typedef enum logic [1:0] {IDLE, DBL, ADD} state_t;

    localparam point_t IDENT = {N'(0), N'(1), N'(0)};

    function automatic logic [N-1:0] red(input logic [N-1:0] a);
        return (a >= MODP) ? a - MODP : a;
    endfunction

    function automatic logic [N-1:0] addm(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, MODP}) ? N'(s - {1'b0, MODP}) : N'(s);
    endfunction

    function automatic logic [N-1:0] subm(input logic [N-1:0] a, input logic [N-1:0] b);
        return addm(a, (b == '0) ? '0 : MODP - b);
    endfunction

    function automatic logic [N-1:0] mulm(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] aa;
        logic [2*N-1:0] bb;
        logic [2*N-1:0] p;
        aa = {{N{1'b0}}, a};
        bb = {{N{1'b0}}, b};
        p  = (aa * bb) % {{N{1'b0}}, MODP};
        return p[N-1:0];
    endfunction

    // Inverse in GF(7); zero maps to zero so a degenerate Z never produces X.
    function automatic logic [N-1:0] invm(input logic [N-1:0] a);
        logic [N-1:0] r;
        case (a)
            N'(1):   r = N'(1);
            N'(2):   r = N'(4);
            N'(3):   r = N'(5);
            N'(4):   r = N'(2);
            N'(5):   r = N'(3);
            N'(6):   r = N'(6);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Projective inputs, normalised affine (Z = 1) output; P + (-P) gives (0,1,0).
    function automatic point_t pointAddition(input point_t a, input point_t b);
        logic [N-1:0] za, zb, x1, y1, x2, y2, lam, x3, y3;
        point_t r;
        za  = invm(red(a.z));
        zb  = invm(red(b.z));
        x1  = mulm(red(a.x), za);
        y1  = mulm(red(a.y), za);
        x2  = mulm(red(b.x), zb);
        y2  = mulm(red(b.y), zb);
        lam = '0;
        x3  = '0;
        y3  = '0;
        r   = IDENT;
        if (a.z == '0) begin
            r = b;
        end else if (b.z == '0) begin
            r = a;
        end else if (x1 == x2 && addm(y1, y2) == '0) begin
            r = IDENT;
        end else begin
            if (x1 == x2)
                lam = mulm(mulm(N'(3), mulm(x1, x1)), invm(addm(y1, y1)));
            else
                lam = mulm(subm(y2, y1), invm(subm(x2, x1)));
            x3 = subm(subm(mulm(lam, lam), x1), x2);
            y3 = subm(mulm(lam, subm(x1, x3)), y1);
            r  = {x3, y3, N'(1)};
        end
        return r;
    endfunction

    state_t         state, state_nxt;
    point_t         acc, acc_nxt;
    logic           acc_inf, acc_inf_nxt;
    point_t         p_q, p_nxt;
    logic [K_W-1:0] k_q, k_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    point_t         out_q, out_nxt;
    logic           done_q, done_nxt;
    point_t         dbl_res;
    point_t         add_res;

    always_comb begin
        dbl_res = pointAddition(acc, acc);
        add_res = pointAddition(acc, p_q);
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        acc_inf_nxt = acc_inf;
        p_nxt       = p_q;
        k_nxt       = k_q;
        idx_nxt     = idx;
        out_nxt     = out_q;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    p_nxt       = {bus.X0, bus.Y0, bus.Z0};
                    k_nxt       = bus.k;
                    acc_inf_nxt = 1'b1;
                    idx_nxt     = IW'(K_W - 1);
                    state_nxt   = DBL;
                end
            end
            DBL: begin
                if (!acc_inf) begin
                    acc_nxt     = dbl_res;
                    acc_inf_nxt = (dbl_res.z == '0);
                end
                state_nxt = ADD;
            end
            ADD: begin
                if (k_q[idx] && p_q.z != '0) begin
                    if (acc_inf) begin
                        acc_nxt     = p_q;
                        acc_inf_nxt = 1'b0;
                    end else begin
                        acc_nxt     = add_res;
                        acc_inf_nxt = (add_res.z == '0);
                    end
                end
                if (idx == '0) begin
                    // Result reflects this final add, so publish the next-state accumulator.
                    out_nxt   = acc_inf_nxt ? IDENT : acc_nxt;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx - IW'(1);
                    state_nxt = DBL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            acc_inf <= 1'b1;
            p_q     <= '0;
            k_q     <= '0;
            idx     <= '0;
            out_q   <= IDENT;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            acc_inf <= acc_inf_nxt;
            p_q     <= p_nxt;
            k_q     <= k_nxt;
            idx     <= idx_nxt;
            out_q   <= out_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.X1   = out_q.x;
    assign bus.Y1   = out_q.y;
    assign bus.Z1   = out_q.z;
    assign bus.done = done_q;
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_scalar_point_mult.sv
// Bench for scalar_point_mult: directed cases plus random curve points against a repeated-addition model.
module tb_scalar_point_mult;
    localparam int N   = 3;
    localparam int K_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    scalar_point_mult_if #(.N(N), .K_W(K_W)) bus ();

    scalar_point_mult #(.N(N), .K_W(K_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int pts_x[$];
    int pts_y[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int md(input int v);
        return ((v % 7) + 7) % 7;
    endfunction

    function automatic int inv7(input int a);
        for (int i = 1; i < 7; i++)
            if (md(a * i) == 1) return i;
        return 0;
    endfunction

    // Affine chord-and-tangent addition on y^2 = x^3 + 1 mod 7.
    function automatic void aff_add(input int x1, input int y1, input int x2, input int y2,
                                    output int x3, output int y3, output bit inf);
        int lam;
        inf = 0;
        x3 = 0;
        y3 = 0;
        if (x1 == x2 && md(y1 + y2) == 0) begin
            inf = 1;
        end else begin
            if (x1 == x2) lam = md(3 * x1 * x1 * inv7(md(2 * y1)));
            else          lam = md((y2 - y1) * inv7(md(x2 - x1)));
            x3 = md(lam * lam - x1 - x2);
            y3 = md(lam * (x1 - x3) - y1);
        end
    endfunction

    // k*P by k-fold repeated addition from the identity.
    function automatic void model_mult(input int kk, input int x, input int y, input int z,
                                       output int ex, output int ey, output int ez);
        int ax, ay, nx, ny;
        bit ainf, ninf;
        ax = 0; ay = 0; ainf = 1;
        if (z != 0) begin
            for (int i = 0; i < kk; i++) begin
                if (ainf) begin
                    ax = x; ay = y; ainf = 0;
                end else begin
                    aff_add(ax, ay, x, y, nx, ny, ninf);
                    ax = nx; ay = ny; ainf = ninf;
                end
            end
        end
        ex = ainf ? 0 : ax;
        ey = ainf ? 1 : ay;
        ez = ainf ? 0 : 1;
    endfunction

    task automatic check_out(input string tag, input int ex, input int ey, input int ez);
        chk({tag, ".X1"}, 32'(bus.X1), ex);
        chk({tag, ".Y1"}, 32'(bus.Y1), ey);
        chk({tag, ".Z1"}, 32'(bus.Z1), ez);
    endtask

    task automatic do_op(input int kk, input int x, input int y, input int z, input string tag);
        int ex, ey, ez, cyc, bc;
        model_mult(kk, x, y, z, ex, ey, ez);
        bus.start = 1'b1;
        bus.k  = K_W'(kk);
        bus.X0 = N'(x);
        bus.Y0 = N'(y);
        bus.Z0 = N'(z);
        tick();
        bus.start = 1'b0;
        bus.k  = K_W'($urandom);
        bus.X0 = N'($urandom);
        bus.Y0 = N'($urandom);
        bus.Z0 = N'($urandom);
        cyc = 0;
        bc  = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) bc++;
            tick();
            cyc++;
        end
        chk({tag, " latency"}, cyc, 2 * K_W);
        chk({tag, " busy_cycles"}, bc, 2 * K_W);
        chk({tag, " busy_at_done"}, 32'(bus.busy), 0);
        check_out(tag, ex, ey, ez);
        tick();
        chk({tag, " done_width"}, 32'(bus.done), 0);
    endtask

    initial begin
        int dones, sx, sy, sz, ex, ey, ez, pi;
        bus.start = 1'b0;
        bus.k  = '0;
        bus.X0 = '0;
        bus.Y0 = '0;
        bus.Z0 = '0;

        for (int x = 0; x < 7; x++)
            for (int y = 0; y < 7; y++)
                if (md(y * y) == md(x * x * x + 1)) begin
                    pts_x.push_back(x);
                    pts_y.push_back(y);
                end

        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check_out("reset", 0, 1, 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        repeat (5) tick();
        check_out("idle", 0, 1, 0);
        chk("idle busy", 32'(bus.busy), 0);
        chk("idle done", 32'(bus.done), 0);

        do_op(1, 2, 3, 1, "k1");
        check_out("k1 const", 2, 3, 1);
        do_op(0, 2, 3, 1, "k0");
        do_op(11, 1, 1, 0, "ident_in");
        do_op(2, 2, 3, 1, "k2");
        check_out("k2 const", 0, 1, 1);
        do_op(11, 2, 3, 1, "k11");
        for (int kk = 0; kk < 16; kk++) do_op(kk, 2, 3, 1, $sformatf("sweep_k%0d", kk));

        // Second start while busy must be ignored.
        model_mult(3, 2, 3, 1, ex, ey, ez);
        bus.start = 1'b1;
        bus.k = 4'd3;
        bus.X0 = 3'd2; bus.Y0 = 3'd3; bus.Z0 = 3'd1;
        tick();
        bus.start = 1'b0;
        dones = 0;
        sx = -1; sy = -1; sz = -1;
        for (int c = 0; c < 20 && dones == 0; c++) begin
            bus.start = (c == 2) ? 1'b1 : 1'b0;
            if (c == 2) bus.k = 4'd5;
            tick();
            if (bus.done === 1'b1) begin
                dones++;
                sx = int'(bus.X1); sy = int'(bus.Y1); sz = int'(bus.Z1);
            end
        end
        bus.start = 1'b0;
        chk("ignored_start dones", dones, 1);
        chk("ignored_start X1", sx, ex);
        chk("ignored_start Y1", sy, ey);
        chk("ignored_start Z1", sz, ez);
        tick();
        chk("ignored_start done_width", 32'(bus.done), 0);
        do_op(5, 2, 3, 1, "after_done");

        // Reset mid-operation aborts without a done pulse.
        bus.start = 1'b1;
        bus.k = 4'd11;
        bus.X0 = 3'd2; bus.Y0 = 3'd3; bus.Z0 = 3'd1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort busy", 32'(bus.busy), 0);
        check_out("abort", 0, 1, 0);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        chk("abort dones", dones, 0);
        check_out("abort hold", 0, 1, 0);
        do_op(11, 2, 3, 1, "post_abort");

        for (int r = 0; r < 40; r++) begin
            pi = $urandom_range(0, pts_x.size() - 1);
            if ($urandom_range(0, 7) == 0)
                do_op($urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 6), 0,
                      $sformatf("rand%0d_ident", r));
            else
                do_op($urandom_range(0, 15), pts_x[pi], pts_y[pi], 1, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/scalar_point_mult.md
Name: scalar_point_mult

Overview:
- Sequential double-and-add scalar multiplier: computes Q = k·P for a projective point P = (X0:Y0:Z0) and an unsigned scalar k.
- Sits directly upstream of the C2 point-addition stage in the encryption datapath and supplies r·E2. It replaces the repeated-addition point generator for large multiples.
- Uses the codebase's combinational pointAddition for both add and double, with doubling done as pointAddition(Q,Q). Identity handling is done locally, so pointAddition is never fed the identity.

Parameters:
- N, 3, coordinate width in bits (matches pointAddition).
- K_W, 4, scalar width in bits; the iteration count is fixed at K_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- k  input  K_W  scalar; latched when start is accepted.
- X0  input  N  base point X; latched when start is accepted.
- Y0  input  N  base point Y; latched when start is accepted.
- Z0  input  N  base point Z; latched when start is accepted. Z0 == 0 means the identity.
- X1  output  N  result X; registered, held until the next completion.
- Y1  output  N  result Y; registered, held until the next completion.
- Z1  output  N  result Z; registered, held until the next completion.
- busy  output  1  high from the cycle after start is accepted until the cycle in which done is high.
- done  output  1  single-cycle completion pulse; X1/Y1/Z1 are valid in the same cycle.

Behaviour:
- Reset (reset == 0 at a rising edge): state = IDLE, busy = 0, done = 0, (X1,Y1,Z1) = identity (0,1,0). Accumulator and index are cleared.
- Reset overrides everything. Asserting it mid-operation aborts the operation, and no done pulse is produced.
- Internal state: accumulator (AX,AY,AZ), acc_inf flag, latched P and k, bit index idx (width clog2(K_W)), FSM state.
- FSM states: IDLE, DBL, ADD.
- IDLE:
  - On start = 1: latch P and k, set acc_inf = 1, set idx = K_W-1, go to DBL.
  - start = 0: stay in IDLE; done = 0.
- DBL:
  - If acc_inf: accumulator unchanged.
  - Otherwise: acc <= pointAddition(acc, acc); if the result has Z == 0, set acc_inf = 1.
  - Always go to ADD.
- ADD:
  - If k[idx] = 1 and P has Z0 != 0:
    - acc_inf = 1: acc <= P, acc_inf <= 0 (bypass).
    - acc_inf = 0: acc <= pointAddition(acc, P); if the result has Z == 0, set acc_inf = 1.
  - If k[idx] = 0 or P is the identity: accumulator unchanged.
  - If idx == 0: load X1/Y1/Z1 with acc (or (0,1,0) if acc_inf), pulse done = 1 for one cycle, busy <= 0, go to IDLE.
  - Otherwise: idx <= idx-1, go to DBL.
- Timing is constant, independent of k:
  - The edge that accepts start is edge 0.
  - done is high for exactly the one cycle following edge 2·K_W (8 cycles for K_W = 4).
- A new start may be accepted on the edge that returns to IDLE? No. start is sampled only while state == IDLE, so back-to-back operations are separated by at least one IDLE cycle.
- start while busy is ignored. k and X0/Y0/Z0 changes while busy have no effect.
- k = 0 yields the identity (0,1,0).
- An identity input point yields the identity for any k.
- Outputs change only on completion or reset. They are never partially updated.
- All arithmetic is delegated to pointAddition. No width growth: coordinates stay N bits.

Test Plan:
- Reset held low 2 cycles, then high → X1/Y1/Z1 = (0,1,0), busy = 0, done = 0. Idle 5 cycles with start = 0 → no change.
- P = (2,3,1), k = 4'b0001, start pulse → busy high for 8 cycles. done is high for 1 cycle, exactly 8 cycles after acceptance, with (X1,Y1,Z1) = (2,3,1).
- P = (2,3,1), k = 0 → done after 8 cycles with output (0,1,0). Also P = (1,1,0) with k = 4'b1011 → output (0,1,0).
- P = (2,3,1), k = 2, then k = 4'b1011 → outputs equal the golden model (pointAddition(P,P), and 11-fold repeated addition of P). Sweep all k in 0..15 against the model.
- Start with k = 3, then pulse start again with k = 5 at cycle 3 → second start is ignored. Exactly one done, with the k = 3 result. A start one cycle after done is accepted.
- Start, then drive reset low at cycle 4 for 1 cycle → busy = 0 next cycle. No done within 20 cycles, outputs = (0,1,0). A subsequent start completes normally.
